// File: rtl/jt12_timers_ab_if.sv
// Control/status bundle between the CPU register file and the Timer A/B block.
interface jt12_timers_ab_if;
  logic       clk_en;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A;
  logic       load_B;
  logic       enable_irq_A;
  logic       enable_irq_B;
  logic       clr_flag_A;
  logic       clr_flag_B;
  logic       flag_A;
  logic       flag_B;
  logic       overflow_A;
  logic       irq_n;

  modport master (
    output clk_en, value_A, value_B, load_A, load_B,
           enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B,
    input  flag_A, flag_B, overflow_A, irq_n
  );

  modport slave (
    input  clk_en, value_A, value_B, load_A, load_B,
           enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B,
    output flag_A, flag_B, overflow_A, irq_n
  );
endinterface

// File: rtl/jt12_timers_ab.sv
// OPN Timer A (10-bit) and Timer B (8-bit, /B_DIV prescaled) with sticky flags and IRQ.
module jt12_timers_ab #(
  parameter int SLOT_DIV = 24,
  parameter int B_DIV    = 16
) (
  input  logic             clk,
  input  logic             rst,
  jt12_timers_ab_if.slave  tmr
);
  localparam logic [4:0] PRE_LAST = 5'(SLOT_DIV - 1);
  localparam logic [3:0] SUB_LAST = 4'(B_DIV - 1);

  logic [4:0] pre_q,   pre_d;
  logic [3:0] sub_b_q, sub_b_d;
  logic [9:0] cnt_a_q, cnt_a_d;
  logic [7:0] cnt_b_q, cnt_b_d;
  logic       last_a_q, last_b_q;
  logic       flag_a_q, flag_a_d;
  logic       flag_b_q, flag_b_d;
  logic       ovf_a_q,  ovf_a_d;

  logic tick, rise_a, rise_b, step_b, ovf_b;

  assign tick   = tmr.clk_en && (pre_q == PRE_LAST);
  assign rise_a = tmr.load_A && !last_a_q;
  assign rise_b = tmr.load_B && !last_b_q;
  // A load edge swallows a coincident tick, so no overflow can happen on it
  assign ovf_a_d = tmr.load_A && !rise_a && tick && (cnt_a_q == 10'h3ff);
  assign step_b  = tmr.load_B && !rise_b && tick && (sub_b_q == SUB_LAST);
  assign ovf_b   = step_b && (cnt_b_q == 8'hff);

  always_comb begin
    pre_d = pre_q;
    if (tmr.clk_en) pre_d = tick ? 5'd0 : pre_q + 5'd1;

    cnt_a_d = cnt_a_q;
    if (rise_a)                     cnt_a_d = tmr.value_A;
    else if (ovf_a_d)               cnt_a_d = tmr.value_A;
    else if (tmr.load_A && tick)    cnt_a_d = cnt_a_q + 10'd1;

    sub_b_d = sub_b_q;
    cnt_b_d = cnt_b_q;
    if (rise_b) begin
      sub_b_d = 4'd0;
      cnt_b_d = tmr.value_B;
    end else if (tmr.load_B && tick) begin
      sub_b_d = step_b ? 4'd0 : sub_b_q + 4'd1;
      if (step_b) cnt_b_d = ovf_b ? tmr.value_B : cnt_b_q + 8'd1;
    end

    // set beats a coincident clear
    flag_a_d = flag_a_q;
    if (ovf_a_d && tmr.enable_irq_A) flag_a_d = 1'b1;
    else if (tmr.clr_flag_A)         flag_a_d = 1'b0;

    flag_b_d = flag_b_q;
    if (ovf_b && tmr.enable_irq_B)   flag_b_d = 1'b1;
    else if (tmr.clr_flag_B)         flag_b_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      sub_b_q  <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      last_a_q <= 1'b0;
      last_b_q <= 1'b0;
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
      ovf_a_q  <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      sub_b_q  <= sub_b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      last_a_q <= tmr.load_A;
      last_b_q <= tmr.load_B;
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
      ovf_a_q  <= ovf_a_d;
    end
  end

  assign tmr.flag_A     = flag_a_q;
  assign tmr.flag_B     = flag_b_q;
  assign tmr.overflow_A = ovf_a_q;
  assign tmr.irq_n      = ~(flag_a_q | flag_b_q);
endmodule
